vdmem_resp: RTL and testbench
=============================

# vdmem_resp

Data-memory responder for the vector execution unit's DMEM request interface. It accepts requests from `vexu`, held until acknowledged, and stores data in a local byte-addressable word array. It returns read data and response status after a configurable number of wait states. It is the memory-side end of the `vexu2dmem_*` / `dmem2vexu_*` protocol, used as a vector TCM and as the bench's DMEM model.

## Interface
Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; must be a power of two, at least 4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0; must be aligned to `DEPTH_WORDS*4`.
- `WAIT_CYCLES`, default 0: extra cycles between acceptance and response; range 0–15.

Ports:
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `dmem_req`, in, 1: request valid; requester holds cmd, width, addr and wdata stable until it sees `dmem_req_ack`.
- `dmem_cmd`, in, `type_scr1_mem_cmd_e`: `SCR1_MEM_CMD_RD` or `SCR1_MEM_CMD_WR`.
- `dmem_width`, in, `type_scr1_mem_width_e`: BYTE, HWORD or WORD.
- `dmem_addr`, in, `SCR1_DMEM_AWIDTH`: byte address.
- `dmem_wdata`, in, `SCR1_DMEM_DWIDTH`: write data, LSB-justified.
- `dmem_req_ack`, out, 1: request accepted this cycle.
- `dmem_rdata`, out, `SCR1_DMEM_DWIDTH`: read data, LSB-justified and zero-extended; valid only with `RDY_OK` on a read.
- `dmem_resp`, out, `type_scr1_mem_resp_e`: `NOTRDY`, `RDY_OK` or `RDY_ER`.

## Operation
- States: IDLE, WAIT, RESP. Reset enters IDLE.
- `dmem_req_ack = dmem_req & (state==IDLE | state==RESP)`. Acceptance is the cycle where both `dmem_req` and `dmem_req_ack` are 1.
- On acceptance:
  - Capture cmd, width, addr and wdata in a request register.
  - Load the wait counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES>0`, otherwise go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - Go to RESP on the edge where the counter equals 1.
  - `dmem_req_ack`=0.
- Entering RESP is the commit edge:
  - Writes update the array at this edge.
  - Reads sample the array at this edge into `dmem_rdata`.
- RESP lasts exactly one cycle and drives `RDY_OK` or `RDY_ER`:
  - With a new acceptance in the same cycle, go to WAIT or RESP per the acceptance rules.
  - Otherwise go to IDLE.
- Byte lanes come from `addr[1:0]` and width:
  - BYTE: 1 lane at `addr[1:0]`.
  - HWORD: 2 lanes at `addr[1]*2`.
  - WORD: all 4 lanes.
- Writes shift `wdata` left by `8*addr[1:0]` into the selected lanes; other lanes are unchanged.
- Reads shift the word right by `8*addr[1:0]` and mask to the width.
- Error when the address is outside `[BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS)`:
  - `RDY_ER`, no array write, `dmem_rdata`=0.
- Word index: `(addr-BASE_ADDR)[2 +: log2(DEPTH_WORDS)]`.
- Misalignment handling depends on configuration; see Configuration.

## Timing
- Reset values:
  - State IDLE.
  - `dmem_resp`=`NOTRDY`.
  - `dmem_rdata`=0.
  - `dmem_req_ack` follows `dmem_req`, since state is IDLE.
  - Counter and request register cleared.
  - Array contents are not reset.
- Latency, acceptance edge to response cycle: `1+WAIT_CYCLES`.
- Throughput:
  - `WAIT_CYCLES=0`: one request per cycle, with acceptance overlapping RESP.
  - Otherwise: one request per `1+WAIT_CYCLES` cycles.
- `dmem_resp`=`NOTRDY` in every cycle other than RESP.
- `dmem_rdata` holds its last value outside RESP.
- Read-after-write to the same word, back to back: the read returns the new data, because the write commits before the read samples.
- Reset asserted mid-operation, in WAIT or RESP:
  - Immediately returns to IDLE and NOTRDY.
  - A write still in WAIT is discarded.
  - A write already committed stays committed.
- `dmem_req` dropped before ack is legal; no state change.

## Configuration
- `VDMEM_RESP_MISALIGN_CHK_EN` defined:
  - HWORD with `addr[0]`=1 gives `RDY_ER`.
  - WORD with `addr[1:0]`≠0 gives `RDY_ER`.
  - No array write; `dmem_rdata`=0.
- Not defined:
  - Misalignment is never an error.
  - HWORD ignores `addr[0]`; WORD ignores `addr[1:0]`.
  - Lanes are forced to the aligned positions.
- The out-of-range check is always present.

## Structure
- Shared package (alongside the `scr1_memif` types):
  - `type_vdmem_resp_state_e` (IDLE, WAIT, RESP).
  - Function mapping width and `addr[1:0]` to a 4-bit byte enable.
  - Constant `VDMEM_RESP_WAIT_W`=4.
- One sub-module, `vdmem_resp_ram`:
  - `DEPTH_WORDS`×32 array, synchronous write with 4-bit byte enable, registered read.
  - No reset on the array.
- FSM, counter, request register, range/alignment checks and lane shifting sit in `vdmem_resp`.

## Test plan
- `WAIT_CYCLES=0`, WR WORD 32'hDEADBEEF @0x10, then RD WORD @0x10 back to back:
  - ack in both cycles; RDY_OK, then RDY_OK with rdata 32'hDEADBEEF one cycle after the read is accepted.
- WR BYTE 8'hA5 @0x11, then RD WORD @0x10:
  - rdata 32'hDEADA5EF.
  - RD HWORD @0x12 returns 32'h0000DEAD.
- `WAIT_CYCLES=3`, RD @0x0:
  - ack low for 3 cycles after acceptance.
  - resp NOTRDY ×3, then RDY_OK on the 4th cycle.
  - A second held req is acked in that RESP cycle.
- RD WORD @`BASE_ADDR+4*DEPTH_WORDS`:
  - RDY_ER, rdata 0.
  - WR to the same address leaves all words unchanged.
- WORD WR @0x22 with the macro defined: RDY_ER, memory unchanged. Without the macro: RDY_OK, word 0x20 written.
- `WAIT_CYCLES=2`, WR accepted, `rst_n` low in WAIT:
  - resp NOTRDY and state IDLE immediately.
  - A later read of that word shows the old value.

Source files
------------

// File: rtl/vdmem_resp_pkg.sv
// rtl/vdmem_resp_pkg.sv - shared DMEM protocol types, responder state and lane helpers
package vdmem_resp_pkg;

  localparam int SCR1_DMEM_AWIDTH  = 32;
  localparam int SCR1_DMEM_DWIDTH  = 32;
  localparam int VDMEM_RESP_WAIT_W = 4;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    VDMEM_ST_IDLE = 2'b00,
    VDMEM_ST_WAIT = 2'b01,
    VDMEM_ST_RESP = 2'b10
  } type_vdmem_resp_state_e;

  typedef struct packed {
    type_scr1_mem_cmd_e          cmd;
    type_scr1_mem_width_e        width;
    logic [SCR1_DMEM_AWIDTH-1:0] addr;
    logic [SCR1_DMEM_DWIDTH-1:0] wdata;
  } type_vdmem_req_s;

  // Wider accesses are snapped to their natural lanes regardless of the low address bits.
  function automatic logic [1:0] vdmem_resp_lane(type_scr1_mem_width_e width, logic [1:0] lo);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return lo;
      SCR1_MEM_WIDTH_HWORD: return {lo[1], 1'b0};
      default:              return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] vdmem_resp_be(type_scr1_mem_width_e width, logic [1:0] lo);
    case (width)
      SCR1_MEM_WIDTH_BYTE:  return 4'b0001 << lo;
      SCR1_MEM_WIDTH_HWORD: return lo[1] ? 4'b1100 : 4'b0011;
      default:              return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/vdmem_resp_if.sv
// rtl/vdmem_resp_if.sv - vexu2dmem / dmem2vexu request-response bundle
interface vdmem_resp_if;
  import vdmem_resp_pkg::*;

  logic                        dmem_req;
  type_scr1_mem_cmd_e          dmem_cmd;
  type_scr1_mem_width_e        dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata;
  logic                        dmem_req_ack;
  logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata;
  type_scr1_mem_resp_e         dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/vdmem_resp_ram.sv
// rtl/vdmem_resp_ram.sv - word array with byte-enable write and registered read, no reset
module vdmem_resp_ram #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] idx,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/vdmem_resp.sv
// rtl/vdmem_resp.sv - DMEM responder: request FSM, wait states, range/lane handling
// Optional misaligned-access error check: VDMEM_RESP_MISALIGN_CHK_EN
module vdmem_resp
  import vdmem_resp_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0
) (
  input logic         clk,
  input logic         rst_n,
  vdmem_resp_if.slave dmem
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;
  localparam logic [VDMEM_RESP_WAIT_W-1:0] WAIT_INIT = VDMEM_RESP_WAIT_W'(WAIT_CYCLES);
  localparam logic [VDMEM_RESP_WAIT_W-1:0] CNT_ONE   = VDMEM_RESP_WAIT_W'(1);

  type_vdmem_resp_state_e       state_q, state_d;
  logic [VDMEM_RESP_WAIT_W-1:0] cnt_q, cnt_d;
  type_vdmem_req_s              req_q, bus_req, cur;
  logic [31:0]                  rdata_hold, rsp_data, ram_rdata;
  logic [31:0]                  cur_off, rsp_off, rd_shift;
  logic [1:0]                   cur_lane, rsp_lane;
  logic                         accept, commit, cur_err, rsp_err;

  always_comb begin
    bus_req = '{cmd: dmem.dmem_cmd, width: dmem.dmem_width,
                addr: dmem.dmem_addr, wdata: dmem.dmem_wdata};
    accept  = dmem.dmem_req && (state_q == VDMEM_ST_IDLE || state_q == VDMEM_ST_RESP);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      VDMEM_ST_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = VDMEM_ST_RESP;
      end
      default: begin
        if (accept) begin
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES > 0) ? VDMEM_ST_WAIT : VDMEM_ST_RESP;
        end else begin
          state_d = VDMEM_ST_IDLE;
        end
      end
    endcase
  end

  // The edge entering RESP is the commit edge; with no wait states the request
  // is still only on the bus at that edge, so the array is fed from there.
  always_comb begin
    commit   = (state_d == VDMEM_ST_RESP);
    cur      = (state_q == VDMEM_ST_WAIT) ? req_q : bus_req;
    cur_off  = cur.addr - BASE_ADDR;
    cur_lane = vdmem_resp_lane(cur.width, cur.addr[1:0]);
    rsp_off  = req_q.addr - BASE_ADDR;
    rsp_lane = vdmem_resp_lane(req_q.width, req_q.addr[1:0]);
`ifdef VDMEM_RESP_MISALIGN_CHK_EN
    cur_err  = (cur_off >= SPAN) || (cur_lane != cur.addr[1:0]);
    rsp_err  = (rsp_off >= SPAN) || (rsp_lane != req_q.addr[1:0]);
`else
    cur_err  = (cur_off >= SPAN);
    rsp_err  = (rsp_off >= SPAN);
`endif
  end

  vdmem_resp_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk   (clk),
    .we    (commit && !cur_err && cur.cmd == SCR1_MEM_CMD_WR),
    .re    (commit && !cur_err && cur.cmd == SCR1_MEM_CMD_RD),
    .idx   (cur_off[AW+1:2]),
    .be    (vdmem_resp_be(cur.width, cur.addr[1:0])),
    .wdata (cur.wdata << {cur_lane, 3'b000}),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_shift = ram_rdata >> {rsp_lane, 3'b000};
    rsp_data = rdata_hold;
    if (rsp_err) begin
      rsp_data = '0;
    end else if (req_q.cmd == SCR1_MEM_CMD_RD) begin
      case (req_q.width)
        SCR1_MEM_WIDTH_BYTE:  rsp_data = {24'h0, rd_shift[7:0]};
        SCR1_MEM_WIDTH_HWORD: rsp_data = {16'h0, rd_shift[15:0]};
        default:              rsp_data = rd_shift;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= VDMEM_ST_IDLE;
      cnt_q      <= '0;
      req_q      <= '0;
      rdata_hold <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) req_q <= bus_req;
      if (state_q == VDMEM_ST_RESP) rdata_hold <= rsp_data;
    end
  end

  assign dmem.dmem_req_ack = accept;
  assign dmem.dmem_rdata   = (state_q == VDMEM_ST_RESP) ? rsp_data : rdata_hold;
  assign dmem.dmem_resp    = (state_q != VDMEM_ST_RESP) ? SCR1_MEM_RESP_NOTRDY :
                             rsp_err ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;

endmodule

// File: tb/tb_vdmem_resp.sv
// tb/tb_vdmem_resp.sv - directed bench for vdmem_resp at 0, 3 and 2 wait states
module tb_vdmem_resp;
  import vdmem_resp_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec  = 0;
  int   nfail = 0;

  localparam logic [31:0] OK = 32'(SCR1_MEM_RESP_RDY_OK);
  localparam logic [31:0] ER = 32'(SCR1_MEM_RESP_RDY_ER);
  localparam logic [31:0] NR = 32'(SCR1_MEM_RESP_NOTRDY);

  always #5 clk = ~clk;

  vdmem_resp_if b0 ();
  vdmem_resp_if b3 ();
  vdmem_resp_if b2 ();

  vdmem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u0 (.clk(clk), .rst_n(rst_n), .dmem(b0));
  vdmem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u3 (.clk(clk), .rst_n(rst_n), .dmem(b3));
  vdmem_resp #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u2 (.clk(clk), .rst_n(rst_n), .dmem(b2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic rq, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                      input logic [31:0] a, input logic [31:0] d);
    b0.dmem_req = rq; b0.dmem_cmd = c; b0.dmem_width = w; b0.dmem_addr = a; b0.dmem_wdata = d;
    #1;
  endtask

  task automatic drv3(input logic rq, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                      input logic [31:0] a, input logic [31:0] d);
    b3.dmem_req = rq; b3.dmem_cmd = c; b3.dmem_width = w; b3.dmem_addr = a; b3.dmem_wdata = d;
    #1;
  endtask

  task automatic drv2(input logic rq, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                      input logic [31:0] a, input logic [31:0] d);
    b2.dmem_req = rq; b2.dmem_cmd = c; b2.dmem_width = w; b2.dmem_addr = a; b2.dmem_wdata = d;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drv0(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    drv3(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    drv2(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);

    // reset state
    @(negedge clk); drv0(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    chk("rst_resp", 32'(b0.dmem_resp), NR);
    chk("rst_rdata", b0.dmem_rdata, 32'h0);
    chk("rst_ack_lo", 32'(b0.dmem_req_ack), 32'd0);
    drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    chk("rst_ack_follows_req", 32'(b0.dmem_req_ack), 32'd1);
    drv0(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    @(negedge clk); rst_n = 1'b1;

    // zero wait states, back-to-back traffic
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h10, 32'hDEADBEEF);
    chk("w0_wr_ack", 32'(b0.dmem_req_ack), 32'd1);
    chk("w0_wr_notrdy", 32'(b0.dmem_resp), NR);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    chk("w0_rd_ack", 32'(b0.dmem_req_ack), 32'd1);
    chk("w0_wr_resp", 32'(b0.dmem_resp), OK);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_BYTE, 32'h11, 32'h000000A5);
    chk("raw_resp", 32'(b0.dmem_resp), OK);
    chk("raw_rdata", b0.dmem_rdata, 32'hDEADBEEF);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h10, 32'h0);
    chk("wrbyte_resp", 32'(b0.dmem_resp), OK);
    chk("wrbyte_rdata_hold", b0.dmem_rdata, 32'hDEADBEEF);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_HWORD, 32'h12, 32'h0);
    chk("byte_merge", b0.dmem_rdata, 32'hDEADA5EF);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h11111111);
    chk("hword_hi", b0.dmem_rdata, 32'h0000DEAD);

    // out of range: word 16 of a 16-word array would alias onto word 0
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h40, 32'h0);
    chk("w0_word0_resp", 32'(b0.dmem_resp), OK);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h40, 32'hFFFFFFFF);
    chk("oor_rd_resp", 32'(b0.dmem_resp), ER);
    chk("oor_rd_rdata", b0.dmem_rdata, 32'h0);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    chk("oor_wr_resp", 32'(b0.dmem_resp), ER);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h12345678);
    chk("oor_word0_kept_resp", 32'(b0.dmem_resp), OK);
    chk("oor_word0_kept", b0.dmem_rdata, 32'h11111111);

    // misaligned word write
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h22, 32'hCAFEF00D);
    chk("w20_resp", 32'(b0.dmem_resp), OK);
    @(negedge clk); drv0(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h20, 32'h0);
`ifdef VDMEM_RESP_MISALIGN_CHK_EN
    chk("mis_resp", 32'(b0.dmem_resp), ER);
    chk("mis_rdata", b0.dmem_rdata, 32'h0);
`else
    chk("mis_resp", 32'(b0.dmem_resp), OK);
    chk("mis_rdata", b0.dmem_rdata, 32'h11111111);
`endif
    @(negedge clk); drv0(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    chk("mis_rd_resp", 32'(b0.dmem_resp), OK);
`ifdef VDMEM_RESP_MISALIGN_CHK_EN
    chk("mis_word20", b0.dmem_rdata, 32'h12345678);
`else
    chk("mis_word20", b0.dmem_rdata, 32'hCAFEF00D);
`endif
    @(negedge clk); #1;
    chk("idle_notrdy", 32'(b0.dmem_resp), NR);
`ifdef VDMEM_RESP_MISALIGN_CHK_EN
    chk("idle_rdata_hold", b0.dmem_rdata, 32'h12345678);
`else
    chk("idle_rdata_hold", b0.dmem_rdata, 32'hCAFEF00D);
`endif

    // three wait states, second request held through the wait
    @(negedge clk); drv3(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0BADF00D);
    chk("w3_wr_ack", 32'(b3.dmem_req_ack), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); drv3(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
      chk($sformatf("w3_wait%0d_ack", i), 32'(b3.dmem_req_ack), 32'd0);
      chk($sformatf("w3_wait%0d_resp", i), 32'(b3.dmem_resp), NR);
    end
    @(negedge clk); drv3(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    chk("w3_resp_ok", 32'(b3.dmem_resp), OK);
    chk("w3_held_ack", 32'(b3.dmem_req_ack), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); drv3(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
      chk($sformatf("w3_rdwait%0d_resp", i), 32'(b3.dmem_resp), NR);
    end
    @(negedge clk); #1;
    chk("w3_rd_resp", 32'(b3.dmem_resp), OK);
    chk("w3_rd_rdata", b3.dmem_rdata, 32'h0BADF00D);

    // two wait states, reset while a write is waiting
    @(negedge clk); drv2(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h4, 32'hAAAA5555);
    chk("w2_wr1_ack", 32'(b2.dmem_req_ack), 32'd1);
    @(negedge clk); drv2(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("w2_wr1_resp", 32'(b2.dmem_resp), OK);
    @(negedge clk); drv2(1'b1, SCR1_MEM_CMD_WR, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h12121212);
    chk("w2_wr2_ack", 32'(b2.dmem_req_ack), 32'd1);
    @(negedge clk); drv2(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    chk("w2_in_wait", 32'(u2.state_q), 32'(VDMEM_ST_WAIT));
    rst_n = 1'b0; #1;
    chk("rst_mid_resp", 32'(b2.dmem_resp), NR);
    chk("rst_mid_state", 32'(u2.state_q), 32'(VDMEM_ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); drv2(1'b1, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h4, 32'h0);
    @(negedge clk); drv2(1'b0, SCR1_MEM_CMD_RD, SCR1_MEM_WIDTH_WORD, 32'h0, 32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("rst_discard_resp", 32'(b2.dmem_resp), OK);
    chk("rst_discard_rdata", b2.dmem_rdata, 32'hAAAA5555);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
